reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/rst_sync.sv | 23 ++
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
// Holds the sequencer FSM encoding and the parameter defaults.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SOFT    = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_OUT     = 4;
    localparam int DEF_STAGE_DLY   = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SOFT_LEN    = 4;

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously with rst and deasserts
// after STAGES clean clock edges.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for NUM_OUT domains plus per-channel soft resets
// served one at a time with fixed (lowest-index-first) priority.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int STAGE_DLY   = DEF_STAGE_DLY,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SOFT_LEN    = DEF_SOFT_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_OUT-1:0] soft_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic [NUM_OUT-1:0] soft_ack,
    output logic               all_ready
);

    localparam int IDX_W  = $clog2(NUM_OUT);
    localparam int CNT_W  = $clog2(STAGE_DLY + 1);
    localparam int SOFT_W = $clog2(SOFT_LEN + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [SOFT_W-1:0] SOFT_LAST  = SOFT_W'(SOFT_LEN - 1);

    logic sync_rst;

    seq_state_t         state, state_next;
    logic [CNT_W-1:0]   stage_cnt, stage_cnt_next;
    logic [SOFT_W-1:0]  soft_cnt, soft_cnt_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [IDX_W-1:0]   sel, sel_next;
    logic [IDX_W-1:0]   grant;
    logic [NUM_OUT-1:0] rst_out_next;
    logic [NUM_OUT-1:0] ack_next;
    logic [NUM_OUT-1:0] elig, elig_next;
    logic [NUM_OUT-1:0] req;

    rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk     (clk),
        .rst     (rst),
        .sync_rst(sync_rst)
    );

    // rst hits every register directly so outputs assert with no clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            stage_cnt <= '0;
            soft_cnt  <= '0;
            idx       <= '0;
            sel       <= '0;
            rst_out   <= '1;
            soft_ack  <= '0;
            elig      <= '1;
        end else begin
            state     <= state_next;
            stage_cnt <= stage_cnt_next;
            soft_cnt  <= soft_cnt_next;
            idx       <= idx_next;
            sel       <= sel_next;
            rst_out   <= rst_out_next;
            soft_ack  <= ack_next;
            elig      <= elig_next;
        end
    end

    assign req = soft_req & elig;

    always_comb begin
        grant = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next     = state;
        stage_cnt_next = stage_cnt;
        soft_cnt_next  = soft_cnt;
        idx_next       = idx;
        sel_next       = sel;
        rst_out_next   = rst_out;
        ack_next       = '0;
        // A channel re-arms once its request is seen low on any edge.
        elig_next      = elig | ~soft_req;

        case (state)
            SYNC: begin
                if (!sync_rst) begin
                    state_next     = RELEASE;
                    stage_cnt_next = '0;
                    idx_next       = '0;
                end
            end
            RELEASE: begin
                if (stage_cnt == STAGE_LAST) begin
                    rst_out_next[idx] = 1'b0;
                    stage_cnt_next    = '0;
                    if (idx == LAST_IDX) begin
                        state_next = RUN;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    stage_cnt_next = stage_cnt + 1'b1;
                end
            end
            RUN: begin
                if (|req) begin
                    state_next          = SOFT;
                    sel_next            = grant;
                    rst_out_next[grant] = 1'b1;
                    soft_cnt_next       = '0;
                end
            end
            SOFT: begin
                if (soft_cnt == SOFT_LAST) begin
                    state_next        = RUN;
                    rst_out_next[sel] = 1'b0;
                    ack_next[sel]     = 1'b1;
                    elig_next[sel]    = 1'b0;
                end else begin
                    soft_cnt_next = soft_cnt + 1'b1;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    assign all_ready = (state == RUN) && (rst_out == '0);

endmodule
